// File: rtl/op_register_pkg.sv
// Shared opcode and FSM state definitions for the op_register slice.
package op_register_pkg;

  localparam int unsigned OP_WIDTH = 4;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_NOP = 4'd0,
    OP_CLR = 4'd1,
    OP_LD  = 4'd2,
    OP_INC = 4'd3,
    OP_DEC = 4'd4,
    OP_SHR = 4'd5,
    OP_SHL = 4'd6,
    OP_ASR = 4'd7,
    OP_ROR = 4'd8,
    OP_ROL = 4'd9
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // True for the opcodes that run through the shift/rotate stepper.
  function automatic logic is_shift(input logic [OP_WIDTH-1:0] op);
    return (op >= OP_SHR) && (op <= OP_ROL);
  endfunction

endpackage

// File: rtl/op_register_if.sv
// Operation port of op_register: request side driven by the controller.
interface op_register_if #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned SHAMT_WIDTH = $clog2(DATA_WIDTH)
) ();
  import op_register_pkg::*;

  logic                   op_valid;
  logic                   op_ready;
  logic [OP_WIDTH-1:0]    op;
  logic [DATA_WIDTH-1:0]  in;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   fill;
  logic [DATA_WIDTH-1:0]  out;
  logic                   busy;
  logic                   done;
  logic                   carry;
  logic                   zero;
  logic                   neg;

  modport master (
    output op_valid, op, in, shamt, fill,
    input  op_ready, out, busy, done, carry, zero, neg
  );

  modport slave (
    input  op_valid, op, in, shamt, fill,
    output op_ready, out, busy, done, carry, zero, neg
  );

endinterface

// File: rtl/op_register_shift_step.sv
// One-bit shift/rotate step; non-shift opcodes pass the value through.
module shift_step
  import op_register_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] value,
  input  logic [OP_WIDTH-1:0]   op,
  input  logic                  fill,
  output logic [DATA_WIDTH-1:0] next_value,
  output logic                  bit_out
);

  // Select the single-step result and the bit that falls off the end.
  always_comb begin
    next_value = value;
    bit_out    = 1'b0;
    case (op)
      OP_SHR: begin next_value = {fill, value[DATA_WIDTH-1:1]};             bit_out = value[0]; end
      OP_SHL: begin next_value = {value[DATA_WIDTH-2:0], fill};             bit_out = value[DATA_WIDTH-1]; end
      OP_ASR: begin next_value = {value[DATA_WIDTH-1], value[DATA_WIDTH-1:1]}; bit_out = value[0]; end
      OP_ROR: begin next_value = {value[0], value[DATA_WIDTH-1:1]};         bit_out = value[0]; end
      OP_ROL: begin next_value = {value[DATA_WIDTH-2:0], value[DATA_WIDTH-1]}; bit_out = value[DATA_WIDTH-1]; end
      default: ;
    endcase
  end

endmodule

// File: rtl/op_register.sv
// Working register with clear/load/inc/dec and iterative multi-bit shifts.
module op_register
  import op_register_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input logic         clk,
  input logic         rst,
  op_register_if.slave bus
);

  state_e                 state;
  logic [SHAMT_WIDTH-1:0] cnt;
  logic [OP_WIDTH-1:0]    op_q;
  logic                   fill_q;
  logic [DATA_WIDTH-1:0]  out_q;
  logic                   carry_q;
  logic                   done_q;

  logic [OP_WIDTH-1:0]    step_op;
  logic                   step_fill;
  logic [DATA_WIDTH-1:0]  step_val;
  logic                   step_bit;
  logic [DATA_WIDTH-1:0]  addend;
  logic [DATA_WIDTH-1:0]  sum;

  // First step uses the live request; later steps use the captured op/fill.
  always_comb begin
    step_op   = bus.op;
    step_fill = bus.fill;
    if (state == ST_SHIFT) begin
      step_op   = op_q;
      step_fill = fill_q;
    end
  end

  // INC/DEC share one adder: +1 or +all-ones (i.e. -1).
  assign addend = (bus.op == OP_DEC) ? '1 : DATA_WIDTH'(1);
  assign sum    = out_q + addend;

  shift_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .value      (out_q),
    .op         (step_op),
    .fill       (step_fill),
    .next_value (step_val),
    .bit_out    (step_bit)
  );

  // Control FSM with the output, carry, counter and captured-op registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      op_q    <= OP_NOP;
      fill_q  <= 1'b0;
      out_q   <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.op_valid) begin
            done_q <= 1'b1;
            case (bus.op)
              OP_CLR: begin out_q <= '0;     carry_q <= 1'b0; end
              OP_LD:  begin out_q <= bus.in; carry_q <= 1'b0; end
              OP_INC: begin out_q <= sum;    carry_q <= &out_q; end
              OP_DEC: begin out_q <= sum;    carry_q <= ~|out_q; end
              default: begin
                if (is_shift(bus.op)) begin
                  if (bus.shamt == '0) begin
                    carry_q <= 1'b0;
                  end else begin
                    out_q   <= step_val;
                    carry_q <= step_bit;
                    if (bus.shamt != SHAMT_WIDTH'(1)) begin
                      state  <= ST_SHIFT;
                      cnt    <= bus.shamt - SHAMT_WIDTH'(1);
                      op_q   <= bus.op;
                      fill_q <= bus.fill;
                      done_q <= 1'b0;
                    end
                  end
                end
              end
            endcase
          end
        end
        ST_SHIFT: begin
          out_q   <= step_val;
          carry_q <= step_bit;
          cnt     <= cnt - SHAMT_WIDTH'(1);
          if (cnt == SHAMT_WIDTH'(1)) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.op_ready = (state == ST_IDLE);
  assign bus.busy     = (state == ST_SHIFT);
  assign bus.out      = out_q;
  assign bus.carry    = carry_q;
  assign bus.done     = done_q;
  assign bus.zero     = (out_q == '0);
  assign bus.neg      = out_q[DATA_WIDTH-1];

endmodule

// File: tb/tb_op_register.sv
// Self-checking bench for op_register (DATA_WIDTH=16).
module tb_op_register;
  import op_register_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned SW = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  op_register_if #(.DATA_WIDTH(W), .SHAMT_WIDTH(SW)) bus ();

  op_register #(.DATA_WIDTH(W), .SHAMT_WIDTH(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: whole-operation result {carry, value} from plain arithmetic.
  function automatic logic [16:0] model_op(input int op, input logic [15:0] v, input logic c,
                                           input logic [15:0] d, input int k, input logic f);
    logic [31:0] u;
    logic [31:0] r;
    logic        cy;
    u = {16'h0, v};
    r = u;
    cy = c;
    case (op)
      1: begin r = 0; cy = 1'b0; end
      2: begin r = {16'h0, d}; cy = 1'b0; end
      3: begin r = u + 1; cy = (v == 16'hFFFF); end
      4: begin r = u - 1; cy = (v == 16'h0000); end
      5, 6, 7, 8, 9: begin
        if (k == 0) begin
          cy = 1'b0;
        end else begin
          case (op)
            5: begin r = (u >> k) | (f ? (32'hFFFF << (16 - k)) : 32'h0); cy = v[k-1]; end
            6: begin r = (u << k) | (f ? ((32'h1 << k) - 1) : 32'h0);     cy = v[16-k]; end
            7: begin r = (u >> k) | (v[15] ? (32'hFFFF << (16 - k)) : 32'h0); cy = v[k-1]; end
            8: begin r = (u >> k) | (u << (16 - k)); cy = v[k-1]; end
            default: begin r = (u << k) | (u >> (16 - k)); cy = v[16-k]; end
          endcase
        end
      end
      default: ;
    endcase
    return {cy, r[15:0]};
  endfunction

  // Issue one op and count edges until done (lat=-1 if it never comes).
  task automatic run_op(input logic [3:0] o, input logic [15:0] d, input logic [3:0] k,
                        input logic f, input bit junk, output int lat);
    bus.op_valid = 1'b1;
    bus.op = o; bus.in = d; bus.shamt = k; bus.fill = f;
    @(posedge clk); #1;
    lat = -1;
    bus.op_valid = junk;
    if (junk) begin
      bus.op = 4'($urandom); bus.in = 16'($urandom);
      bus.shamt = 4'($urandom); bus.fill = 1'($urandom);
    end
    for (int n = 1; n <= 40; n++) begin
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
    bus.op_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.op_valid = 1'b1; bus.op = OP_LD; bus.in = 16'h1234; bus.shamt = '0; bus.fill = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.out !== 16'h0000) begin bad++; $display("FAIL reset_out: got %h want 0000", bus.out); end
    total++; if (bus.carry !== 1'b0) begin bad++; $display("FAIL reset_carry: got %b want 0", bus.carry); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL reset_zero: got %b want 1", bus.zero); end
    rst = 1'b0;
    bus.op_valid = 1'b0;
    total++; if (bus.op_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.op_ready); end
  endtask

  task automatic test_rol();
    logic [15:0] exp_v [4] = '{16'h0003, 16'h0006, 16'h000C, 16'h0018};
    int lat;
    run_op(OP_LD, 16'h8001, 4'd0, 1'b0, 1'b0, lat);
    bus.op_valid = 1'b1; bus.op = OP_ROL; bus.shamt = 4'd4;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.out !== exp_v[i]) begin bad++; $display("FAIL rol_out[%0d]: got %h want %h", i, bus.out, exp_v[i]); end
      total++; if (bus.busy !== (i < 3)) begin bad++; $display("FAIL rol_busy[%0d]: got %b want %b", i, bus.busy, (i < 3)); end
      total++; if (bus.done !== (i == 3)) begin bad++; $display("FAIL rol_done[%0d]: got %b want %b", i, bus.done, (i == 3)); end
      total++; if (bus.op_ready !== (i == 3)) begin bad++; $display("FAIL rol_ready[%0d]: got %b want %b", i, bus.op_ready, (i == 3)); end
      if (i < 3) begin @(posedge clk); #1; end
    end
    total++; if (bus.carry !== 1'b0) begin bad++; $display("FAIL rol_carry: got %b want 0", bus.carry); end
  endtask

  task automatic test_incdec();
    int lat;
    run_op(OP_LD, 16'hFFFF, 4'd0, 1'b0, 1'b0, lat);
    run_op(OP_INC, 16'h0000, 4'd0, 1'b0, 1'b0, lat);
    total++; if (bus.out !== 16'h0000 || bus.carry !== 1'b1 || bus.zero !== 1'b1)
      begin bad++; $display("FAIL inc_wrap: got out=%h c=%b z=%b want 0000 1 1", bus.out, bus.carry, bus.zero); end
    run_op(OP_DEC, 16'h0000, 4'd0, 1'b0, 1'b0, lat);
    total++; if (bus.out !== 16'hFFFF || bus.carry !== 1'b1 || bus.neg !== 1'b1)
      begin bad++; $display("FAIL dec_borrow: got out=%h c=%b n=%b want ffff 1 1", bus.out, bus.carry, bus.neg); end
    run_op(OP_DEC, 16'h0000, 4'd0, 1'b0, 1'b0, lat);
    total++; if (bus.out !== 16'hFFFE || bus.carry !== 1'b0)
      begin bad++; $display("FAIL dec_plain: got out=%h c=%b want fffe 0", bus.out, bus.carry); end
  endtask

  task automatic test_asr_long();
    int lat;
    run_op(OP_LD, 16'h8000, 4'd0, 1'b0, 1'b0, lat);
    run_op(OP_ASR, 16'h0000, 4'd15, 1'b0, 1'b0, lat);
    total++; if (lat !== 15) begin bad++; $display("FAIL asr15_latency: got %0d want 15", lat); end
    total++; if (bus.out !== 16'hFFFF || bus.carry !== 1'b0)
      begin bad++; $display("FAIL asr15_result: got out=%h c=%b want ffff 0", bus.out, bus.carry); end
    run_op(OP_SHR, 16'h0000, 4'd0, 1'b1, 1'b0, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL shr0_latency: got %0d want 1", lat); end
    total++; if (bus.out !== 16'hFFFF || bus.carry !== 1'b0)
      begin bad++; $display("FAIL shr0_result: got out=%h c=%b want ffff 0", bus.out, bus.carry); end
  endtask

  task automatic test_fill_hold();
    int lat;
    run_op(OP_LD, 16'h00F0, 4'd0, 1'b0, 1'b0, lat);
    bus.op_valid = 1'b1; bus.op = OP_SHR; bus.shamt = 4'd3; bus.fill = 1'b1;
    @(posedge clk); #1;
    bus.op_valid = 1'b0; bus.fill = 1'b0; bus.op = OP_ROL; bus.shamt = 4'd1;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      if (bus.done === 1'b1) begin lat = n; break; end
      @(posedge clk); #1;
    end
    total++; if (lat !== 3) begin bad++; $display("FAIL fill_latency: got %0d want 3", lat); end
    total++; if (bus.out !== 16'hE01E || bus.carry !== 1'b0)
      begin bad++; $display("FAIL fill_result: got out=%h c=%b want e01e 0", bus.out, bus.carry); end
  endtask

  task automatic test_abort();
    int lat;
    int pulses;
    run_op(OP_LD, 16'h00FF, 4'd0, 1'b0, 1'b0, lat);
    bus.op_valid = 1'b1; bus.op = OP_SHL; bus.shamt = 4'd8; bus.fill = 1'b0;
    @(posedge clk); #1;
    bus.op = OP_CLR;
    total++; if (bus.out !== 16'h01FE || bus.busy !== 1'b1)
      begin bad++; $display("FAIL abort_step1: got out=%h busy=%b want 01fe 1", bus.out, bus.busy); end
    @(posedge clk); #1;
    total++; if (bus.out !== 16'h03FC) begin bad++; $display("FAIL abort_clr_ignored: got %h want 03fc", bus.out); end
    @(posedge clk); #1;
    total++; if (bus.out !== 16'h07F8) begin bad++; $display("FAIL abort_step3: got %h want 07f8", bus.out); end
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.out !== 16'h0000 || bus.busy !== 1'b0 || bus.done !== 1'b0)
      begin bad++; $display("FAIL abort_reset: got out=%h busy=%b done=%b want 0000 0 0", bus.out, bus.busy, bus.done); end
    rst = 1'b0;
    bus.op_valid = 1'b0;
    pulses = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) pulses++;
    end
    total++; if (pulses !== 0 || bus.out !== 16'h0000)
      begin bad++; $display("FAIL abort_no_done: got pulses=%0d out=%h want 0 0000", pulses, bus.out); end
  endtask

  // Random back-to-back ops (with junk requests while busy) against the model.
  task automatic test_random();
    logic [15:0] m_val;
    logic        m_carry;
    logic [16:0] r;
    logic [3:0]  o;
    logic [15:0] d;
    logic [3:0]  k;
    logic        f;
    int          lat;
    int          exp_lat;
    d = 16'($urandom);
    run_op(OP_LD, d, 4'd0, 1'b0, 1'b0, lat);
    m_val = d;
    m_carry = 1'b0;
    for (int i = 0; i < 80; i++) begin
      o = (i % 3 == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(5, 9));
      d = 16'($urandom);
      k = 4'($urandom);
      f = 1'($urandom);
      run_op(o, d, k, f, 1'(i % 2), lat);
      r = model_op(int'(o), m_val, m_carry, d, int'(k), f);
      m_carry = r[16];
      m_val = r[15:0];
      exp_lat = (o >= 4'd5 && o <= 4'd9 && k != 4'd0) ? int'(k) : 1;
      total++; if (lat !== exp_lat) begin bad++; $display("FAIL rnd_latency[%0d] op=%0d k=%0d: got %0d want %0d", i, o, k, lat, exp_lat); end
      total++; if (bus.out !== m_val || bus.carry !== m_carry)
        begin bad++; $display("FAIL rnd_result[%0d] op=%0d k=%0d: got %h/%b want %h/%b", i, o, k, bus.out, bus.carry, m_val, m_carry); end
      total++; if (bus.zero !== (m_val == 16'h0) || bus.neg !== m_val[15] || bus.op_ready !== 1'b1)
        begin bad++; $display("FAIL rnd_flags[%0d]: got z=%b n=%b rdy=%b want %b %b 1", i, bus.zero, bus.neg, bus.op_ready, (m_val == 16'h0), m_val[15]); end
    end
  endtask

  initial begin
    test_reset();
    test_rol();
    test_incdec();
    test_asr_long();
    test_fill_hold();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
